ble_uart: RTL and testbench
===========================

# ble_uart

Full-duplex 8N1 UART serial link for the BLE module interface; it sits beside the servant RAM/Wishbone fabric. The transmit path serialises a byte on a one-cycle request. The receive path deserialises the incoming line and presents each byte with a one-cycle done strobe. Both paths share one clock and a fixed bit period in clock cycles.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per serial bit; must be ≥ 4.
- BITS, default 8: data bits per frame.
- i_wb_clk  in  1  system clock; all logic on rising edge.
- i_wb_rst  in  1  reset. One clock; reset is asynchronous and active-low.
- tx_active  in  1  transmit request; sampled only while TX is idle.
- tx_dat  in  BITS  byte to send; latched on the accepted request.
- tx_busy  out  1  high from the cycle after acceptance until the tx_done cycle, inclusive.
- tx_done  out  1  one-cycle strobe at end of stop bit.
- o_uart  out  1  serial TX line; idles high.
- i_uart  in  1  serial RX line; asynchronous, idles high.
- rx_active  out  1  high while a frame is being received.
- rx_done  out  1  one-cycle strobe when a valid frame completes.
- rx_dat  out  BITS  last valid received byte; held until the next valid frame.
- rx_err  out  1  one-cycle strobe on a framing error (stop bit low).

## Operation
- Frame format: start bit 0, then BITS data bits LSB first, then one stop bit 1. No parity.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with tx_active=1: latch tx_dat and go to START.
  - Each state drives o_uart for CLKS_PER_BIT cycles.
  - DATA steps a bit index from 0 to BITS-1.
  - On the last cycle of STOP: assert tx_done and return to IDLE.
  - tx_active while busy is ignored; it is not queued.
- RX path:
  - i_uart passes through a 2-flop synchroniser, reset to 1.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised falling edge (1→0) enters START and asserts rx_active.
  - START: at CLKS_PER_BIT/2 cycles, sample the line. If it is 1 (glitch), return to IDLE with no strobes. If it is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, at mid-bit, shifting LSB first.
  - STOP: sample at mid-bit. If 1, load rx_dat and pulse rx_done. If 0, pulse rx_err and leave rx_dat unchanged. Either way, return to IDLE the next cycle.
- TX and RX are fully independent; simultaneous activity is allowed.

## Timing
- Reset values:
  - o_uart=1.
  - tx_busy, tx_done, rx_active, rx_done, rx_err = 0.
  - rx_dat=0.
  - All counters and FSMs cleared to IDLE.
- Reset mid-frame aborts immediately; o_uart returns high asynchronously.
- TX:
  - Request sampled at edge E. The start bit appears on o_uart from E+1.
  - Frame length is (BITS+2)·CLKS_PER_BIT cycles.
  - tx_done is high on the final cycle of the stop bit. A request in the following cycle is accepted.
  - Minimum request-to-request period: (BITS+2)·CLKS_PER_BIT+1 cycles.
- RX:
  - 2-cycle synchroniser latency.
  - rx_done/rx_err occur (BITS+1.5)·CLKS_PER_BIT cycles (±1) after the synchronised falling edge.
  - rx_active drops in the cycle after the strobe.
  - Back-to-back frames are accepted because RX returns to IDLE at mid-stop-bit.
- Counter widths: bit counter $clog2(CLKS_PER_BIT); index counter $clog2(BITS+1). No wrap beyond the terminal count.

## Structure
- Package uart_pkg holds:
  - the FSM state enum (IDLE/START/DATA/STOP), shared by both paths;
  - constants START_BIT=0 and STOP_BIT=1.
- Sub-module uart_tx contains the TX FSM and shifter.
- Sub-module uart_rx contains the synchroniser, RX FSM and shifter.
- ble_uart instantiates one of each and has no other logic.

## Test plan
The bench uses CLKS_PER_BIT=16.
- Reset: assert i_wb_rst low mid-run → o_uart=1, all strobes 0, rx_dat=0.
- TX 0xA5: pulse tx_active → o_uart shows 0,1,0,1,0,0,1,0,1,1, 16 cycles each. tx_done is a single pulse 160 cycles after the start bit began.
- Loopback, o_uart→i_uart: send 0x3C, then 0xFF, then 0x00 back-to-back → rx_done pulses three times with rx_dat = 0x3C, 0xFF, 0x00 in order; rx_err stays 0.
- Glitch: drive i_uart low for 4 cycles → rx_active pulses, then clears; no rx_done, no rx_err.
- Framing error: frame 0x55 with stop bit 0 → rx_err pulses once, rx_done stays 0, rx_dat keeps its prior value.
- Busy: assert tx_active mid-frame → ignored; exactly one frame sent. Reset mid-frame → o_uart high; a new request sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the ble_uart serial link.
// The FSM state type is shared by the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises the line, qualifies the start bit at mid-bit and
// samples data and stop bits at mid-bit, LSB first.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned BITS         = 8
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            i_uart,
    output logic            rx_active,
    output logic            rx_done,
    output logic [BITS-1:0] rx_dat,
    output logic            rx_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BITS - 1);

    uart_state_t     state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] shreg;
    logic            sync1;
    logic            sync2;
    logic            line_q;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_q    <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_active <= 1'b0;
            rx_done   <= 1'b0;
            rx_err    <= 1'b0;
            rx_dat    <= '0;
        end else begin
            sync1   <= i_uart;
            sync2   <= sync1;
            line_q  <= sync2;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (line_q && !sync2) begin
                        rx_active <= 1'b1;
                        state     <= START;
                    end else begin
                        rx_active <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (sync2 != START_BIT) begin
                            rx_active <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {sync2, shreg[BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // leave at mid-stop so a back-to-back start edge is not missed
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (sync2 == STOP_BIT) begin
                            rx_dat  <= shreg;
                            rx_done <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: serialises one latched word per accepted request, LSB first.
// tx_done is registered one cycle early so it coincides with the last stop-bit cycle.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned BITS         = 8
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            tx_active,
    input  logic [BITS-1:0] tx_dat,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            o_uart
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(BITS - 1);

    uart_state_t     state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [BITS-1:0] shreg;

    // shreg[0] always holds the next data bit to put on the line
    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            o_uart  <= STOP_BIT;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    idx    <= '0;
                    o_uart <= STOP_BIT;
                    if (tx_active) begin
                        shreg   <= tx_dat;
                        o_uart  <= START_BIT;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        o_uart <= shreg[0];
                        shreg  <= shreg >> 1;
                        state  <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            o_uart <= STOP_BIT;
                            state  <= STOP;
                        end else begin
                            idx    <= idx + 1'b1;
                            o_uart <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ble_uart.sv
// Full-duplex 8N1 UART for the BLE module interface.
// Pure wrapper around independent transmit and receive paths.
module ble_uart #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned BITS         = 8
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            tx_active,
    input  logic [BITS-1:0] tx_dat,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            o_uart,
    input  logic            i_uart,
    output logic            rx_active,
    output logic            rx_done,
    output logic [BITS-1:0] rx_dat,
    output logic            rx_err
);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BITS        (BITS)
    ) u_tx (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .tx_active(tx_active),
        .tx_dat   (tx_dat),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .o_uart   (o_uart)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .BITS        (BITS)
    ) u_rx (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .i_uart   (i_uart),
        .rx_active(rx_active),
        .rx_done  (rx_done),
        .rx_dat   (rx_dat),
        .rx_err   (rx_err)
    );

endmodule

// File: tb/tb_ble_uart.sv
// Scoreboard bench for ble_uart at 16 clocks per bit: expected RX bytes are queued
// when frames are launched and compared as rx_done strobes arrive.
module tb_ble_uart;

    localparam int unsigned CPB = 16;
    localparam int unsigned NB  = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          tx_active = 1'b0;
    logic [NB-1:0] tx_dat    = '0;
    logic          tx_busy;
    logic          tx_done;
    logic          o_uart;
    logic          i_uart;
    logic          rx_active;
    logic          rx_done;
    logic [NB-1:0] rx_dat;
    logic          rx_err;
    logic          loop      = 1'b0;
    logic          drv_line  = 1'b1;

    int n_cmp       = 0;
    int n_err       = 0;
    int rx_done_cnt = 0;
    int rx_err_cnt  = 0;
    int tx_done_cnt = 0;
    bit saw_active  = 1'b0;
    logic [NB-1:0] sb[$];

    assign i_uart = loop ? o_uart : drv_line;

    always #5 clk = ~clk;

    ble_uart #(
        .CLKS_PER_BIT(CPB),
        .BITS        (NB)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst_n),
        .tx_active(tx_active),
        .tx_dat   (tx_dat),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .o_uart   (o_uart),
        .i_uart   (i_uart),
        .rx_active(rx_active),
        .rx_done  (rx_done),
        .rx_dat   (rx_dat),
        .rx_err   (rx_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done) tx_done_cnt++;
        if (rx_err) rx_err_cnt++;
        if (rx_active) saw_active = 1'b1;
        if (rx_done) begin
            rx_done_cnt++;
            if (sb.size() == 0)
                check("rx_unexpected", 32'(rx_done), 32'd0);
            else
                check("rx_dat", 32'(rx_dat), 32'(sb.pop_front()));
        end
    end

    task automatic send_req(input logic [NB-1:0] d);
        @(negedge clk);
        tx_active = 1'b1;
        tx_dat    = d;
        @(posedge clk);
        #1 tx_active = 1'b0;
    endtask

    // Cycle c below is the clock period following acceptance edge E plus c.
    task automatic tx_frame_check(input logic [NB-1:0] d);
        logic [9:0] f;
        int nd;
        int dc;
        f  = {1'b1, d, 1'b0};
        nd = 0;
        dc = -1;
        send_req(d);
        for (int c = 0; c < 170; c++) begin
            @(negedge clk);
            if (c < 160 && (c % 16 == 0 || c % 16 == 15))
                check($sformatf("tx_bit%0d_c%0d", c / 16, c), 32'(o_uart), 32'(f[c / 16]));
            if (tx_done) begin
                nd++;
                dc = c;
            end
            if (c == 159) check("tx_busy_last", 32'(tx_busy), 32'd1);
            if (c == 160) begin
                check("tx_busy_after", 32'(tx_busy), 32'd0);
                check("tx_idle_line", 32'(o_uart), 32'd1);
            end
        end
        check("tx_done_pulses", 32'(nd), 32'd1);
        check("tx_done_cycle", 32'(dc), 32'd159);
    endtask

    task automatic send_wait(input logic [NB-1:0] d);
        bit got;
        got = 1'b0;
        send_req(d);
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (tx_done) got = 1'b1;
        end
        check("tx_done_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_rx(input int target);
        for (int c = 0; c < 600 && rx_done_cnt < target; c++) @(negedge clk);
        check("rx_done_count", 32'(rx_done_cnt), 32'(target));
    endtask

    task automatic drive_frame(input logic [NB-1:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            drv_line = f[b];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        drv_line = 1'b1;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int r0;

        repeat (3) @(negedge clk);
        check("rst_o_uart", 32'(o_uart), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_active", 32'(rx_active), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_rx_err", 32'(rx_err), 32'd0);
        check("rst_rx_dat", 32'(rx_dat), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_frame_check(8'hA5);
        check("a5_no_rx", 32'(rx_done_cnt), 32'd0);

        loop = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(8'h3C);
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        send_wait(8'h3C);
        send_wait(8'hFF);
        send_wait(8'h00);
        wait_rx(3);
        check("loop_rx_err", 32'(rx_err_cnt), 32'd0);
        check("loop_sb_empty", 32'(sb.size()), 32'd0);
        repeat (20) @(negedge clk);

        loop = 1'b0;
        drv_line = 1'b1;
        repeat (4) @(negedge clk);
        saw_active = 1'b0;
        drv_line = 1'b0;
        repeat (4) @(negedge clk);
        drv_line = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_active_seen", 32'(saw_active), 32'd1);
        check("glitch_active_clr", 32'(rx_active), 32'd0);
        check("glitch_no_done", 32'(rx_done_cnt), 32'd3);
        check("glitch_no_err", 32'(rx_err_cnt), 32'd0);

        sb.push_back(8'hC3);
        drive_frame(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        wait_rx(4);
        drive_frame(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        check("ferr_err_once", 32'(rx_err_cnt), 32'd1);
        check("ferr_no_done", 32'(rx_done_cnt), 32'd4);
        check("ferr_dat_held", 32'(rx_dat), 32'hC3);

        loop = 1'b1;
        repeat (4) @(negedge clk);
        t0 = tx_done_cnt;
        r0 = rx_done_cnt;
        sb.push_back(8'h96);
        send_req(8'h96);
        repeat (50) @(negedge clk);
        tx_active = 1'b1;
        tx_dat    = 8'h11;
        @(negedge clk);
        tx_active = 1'b0;
        check("busy_mid_frame", 32'(tx_busy), 32'd1);
        repeat (350) @(negedge clk);
        check("busy_one_tx", 32'(tx_done_cnt - t0), 32'd1);
        check("busy_one_rx", 32'(rx_done_cnt - r0), 32'd1);
        check("busy_rx_dat", 32'(rx_dat), 32'h96);

        loop = 1'b0;
        drv_line = 1'b1;
        repeat (4) @(negedge clk);
        send_req(8'h00);
        repeat (40) @(negedge clk);
        check("mid_frame_low", 32'(o_uart), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_o_uart", 32'(o_uart), 32'd1);
        check("arst_tx_busy", 32'(tx_busy), 32'd0);
        check("arst_rx_dat", 32'(rx_dat), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_done", 32'(tx_done_cnt - t0), 32'd1);

        loop = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back(8'h5A);
        tx_frame_check(8'h5A);
        wait_rx(r0 + 2);
        check("final_rx_err", 32'(rx_err_cnt), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
